// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// The result is published on bcd_out only when a conversion completes, so the display never sees partial digits.
module bin2bcd_seq #(
  parameter int          BIN_W    = 14,
  parameter logic [15:0] OVF_CODE = 16'hAAAA
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic [15:0]      bcd_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

  logic [1:0]       state_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [15:0]      scratch_reg;
  logic [3:0]       cnt_reg;
  logic             ovf_flag_reg;
  logic [15:0]      adj;
  logic             in_range;

  assign in_range = (32'(bin_in) <= 32'd9999);

  // Add-3 correction per nibble; no carry between nibbles since inputs stay <= 9999.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                              scratch_reg[4*gi +: 4] + 4'd3 :
                              scratch_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      ovf_flag_reg <= 1'b0;
      bcd_out      <= 16'h0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            bin_reg      <= bin_in;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_flag_reg <= !in_range;
            busy         <= 1'b1;
            state_reg    <= in_range ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          scratch_reg <= {adj[14:0], bin_reg[BIN_W-1]};
          bin_reg     <= {bin_reg[BIN_W-2:0], 1'b0};
          // Counter holds at the last step so it never wraps.
          if (cnt_reg == LAST_STEP) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        DONE: begin
          bcd_out   <= ovf_flag_reg ? OVF_CODE : scratch_reg;
          ovf       <= ovf_flag_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes expected results, a negedge monitor pops and compares on done.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [13:0] bin_in = '0;
  logic        load = 1'b0;
  logic [15:0] bcd_out;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] sb_bcd[$];
  logic        sb_ovf[$];
  int          sb_cyc[$];

  logic [15:0] shown_bcd = 16'h0000;
  logic        shown_ovf = 1'b0;

  bin2bcd_seq #(.BIN_W(14), .OVF_CODE(16'hAAAA)) dut (
    .clk    (clk),
    .clr    (clr),
    .bin_in (bin_in),
    .load   (load),
    .bcd_out(bcd_out),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes one expectation per done pulse; checks display stability while busy.
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      if (done === 1'b1) begin
        if (sb_bcd.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [15:0] eb;
          logic        eo;
          int          ec;
          eb = sb_bcd.pop_front();
          eo = sb_ovf.pop_front();
          ec = sb_cyc.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(eb));
          check("ovf", 32'(ovf), 32'(eo));
          check("done_latency", 32'(cyc), 32'(ec));
          $display("txn: bcd_out=%04h ovf=%0b at cycle %0d (expected %04h/%0b at %0d)",
                   bcd_out, ovf, cyc, eb, eo, ec);
          shown_bcd = eb;
          shown_ovf = eo;
        end
      end else if (busy === 1'b1) begin
        check("bcd_hold_while_busy", 32'(bcd_out), 32'(shown_bcd));
        check("ovf_hold_while_busy", 32'(ovf), 32'(shown_ovf));
      end
    end
  end

  // Called between a negedge and the next posedge; the coming posedge is E0.
  task automatic issue(input int v, input logic [15:0] eb, input logic eo, input bit push);
    load   = 1'b1;
    bin_in = 14'(v);
    if (push) begin
      sb_bcd.push_back(eb);
      sb_ovf.push_back(eo);
      sb_cyc.push_back(cyc + 1 + (eo ? 1 : 15));
    end
    @(posedge clk);
    @(negedge clk);
    load   = 1'b0;
    bin_in = 14'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_bcd.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_timeout", 32'(sb_bcd.size()), 32'd0);
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'hAAAA;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    #1 clr = 1'b0;
    #1;
    check("rst_bcd_out", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    repeat (2) @(negedge clk);
    #1 clr = 1'b1;
    @(negedge clk); #1;

    // Basic conversion with busy timing.
    issue(1234, 16'h1234, 1'b0, 1'b1);
    check("busy_after_e0", 32'(busy), 32'd1);
    drain();
    @(negedge clk); #1;
    check("busy_low_after_done", 32'(busy), 32'd0);

    issue(0,    16'h0000, 1'b0, 1'b1); drain();
    issue(9,    16'h0009, 1'b0, 1'b1); drain();
    issue(10,   16'h0010, 1'b0, 1'b1); drain();
    issue(9999, 16'h9999, 1'b0, 1'b1); drain();
    issue(10000, 16'hAAAA, 1'b1, 1'b1); drain();
    issue(42,   16'h0042, 1'b0, 1'b1); drain();
    issue(16383, 16'hAAAA, 1'b1, 1'b1); drain();
    issue(8191, 16'h8191, 1'b0, 1'b1); drain();

    // Loads while busy (E0+3 and the DONE edge E0+15) are ignored; E0+16 is accepted.
    issue(5678, 16'h5678, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    issue(1111, 16'h1111, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    issue(1111, 16'h1111, 1'b0, 1'b0);
    issue(1111, 16'h1111, 1'b0, 1'b1);
    drain();

    // Reset mid-conversion aborts with no done pulse.
    issue(777, 16'h0777, 1'b0, 1'b1); drain();
    issue(4321, 16'h4321, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    #1 clr = 1'b0;
    #1;
    check("midrst_bcd_out", 32'(bcd_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_ovf", 32'(ovf), 32'h0);
    shown_bcd = 16'h0000;
    shown_ovf = 1'b0;
    repeat (2) @(negedge clk);
    #1 clr = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    issue(4321, 16'h4321, 1'b0, 1'b1); drain();

    // Strided sweep of the input range against an arithmetic reference.
    for (int v = 0; v < 16384; v += 53) begin
      issue(v, ref_bcd(v), (v > 9999), 1'b1);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
